// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: ROM/decoder/hold inputs and phase/PC/latched-operand outputs.
// The sequencer attaches to the slave modport; the surrounding core uses the master modport.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] romData;
  logic              hold;
  logic              twoWord;
  logic              pcLoad;
  logic [ADDR_W-1:0] pcNew;

  logic [2:0]        cycle;
  logic              sync;
  logic [ADDR_W-1:0] pcAddr;
  logic [DATA_W-1:0] opr;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opr2;
  logic [DATA_W-1:0] opa2;
  logic              secondWord;
  logic              instrValid;
  logic [ADDR_W-1:0] instrAddr;

  modport master (
    output romData, hold, twoWord, pcLoad, pcNew,
    input  cycle, sync, pcAddr, opr, opa, opr2, opa2, secondWord, instrValid, instrAddr
  );

  modport slave (
    input  romData, hold, twoWord, pcLoad, pcNew,
    output cycle, sync, pcAddr, opr, opa, opr2, opa2, secondWord, instrValid, instrAddr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Eight-phase nibble fetch sequencer: PC, one/two-word operand latches, instrValid at phase 5; hold freezes all state.
// FETCH_INSTR_ADDR_EN adds the instruction-address capture register; otherwise instrAddr is tied to 0.
module fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  phase_e            phase_q, phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] opr_q, opr_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opr2_q, opr2_d;
  logic [DATA_W-1:0] opa2_q, opa2_d;
  logic              second_q, second_d;
  logic              vld_pend_q, vld_pend_d;
  logic              load_ok;

  // A pending second word must be fetched before any jump is honoured.
  assign load_ok = bus.pcLoad && !(!second_q && bus.twoWord);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PH_A1;
      pc_q       <= '0;
      opr_q      <= '0;
      opa_q      <= '0;
      opr2_q     <= '0;
      opa2_q     <= '0;
      second_q   <= 1'b0;
      vld_pend_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      pc_q       <= pc_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      opr2_q     <= opr2_d;
      opa2_q     <= opa2_d;
      second_q   <= second_d;
      vld_pend_q <= vld_pend_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    pc_d       = pc_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    opr2_d     = opr2_q;
    opa2_d     = opa2_q;
    second_d   = second_q;
    vld_pend_d = vld_pend_q;
    if (!bus.hold) begin
      phase_d = phase_e'(phase_q + 3'd1);
      unique case (phase_q)
        PH_M1: begin
          if (second_q) opr2_d = bus.romData;
          else          opr_d  = bus.romData;
        end
        PH_M2: begin
          if (second_q) opa2_d = bus.romData;
          else          opa_d  = bus.romData;
          vld_pend_d = second_q || !bus.twoWord;
        end
        PH_X1: vld_pend_d = 1'b0;
        PH_X3: begin
          second_d = !second_q && bus.twoWord;
          pc_d     = load_ok ? bus.pcNew : pc_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Pulse is qualified by hold so a stalled phase 5 still produces exactly one cycle of instrValid.
  assign bus.instrValid = (phase_q == PH_X1) && vld_pend_q && !bus.hold;
  assign bus.cycle      = phase_q;
  assign bus.sync       = (phase_q == PH_X3);
  assign bus.pcAddr     = pc_q;
  assign bus.opr        = opr_q;
  assign bus.opa        = opa_q;
  assign bus.opr2       = opr2_q;
  assign bus.opa2       = opa2_q;
  assign bus.secondWord = second_q;

`ifdef FETCH_INSTR_ADDR_EN
  logic [ADDR_W-1:0] iaddr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iaddr_q <= '0;
    end else if (!bus.hold && (phase_q == PH_A1) && !second_q) begin
      iaddr_q <= pc_q;
    end
  end

  assign bus.instrAddr = iaddr_q;
`else
  assign bus.instrAddr = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, single/two-word fetch, jumps, PC wrap, hold and mid-instruction reset.
module tb_fetch_sequencer;
  localparam int AW = 12;
  localparam int DW = 4;

`ifdef FETCH_INSTR_ADDR_EN
  localparam logic [AW-1:0] EXP_IA_2W = 12'h010;
`else
  localparam logic [AW-1:0] EXP_IA_2W = 12'h000;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   vcount, vphase, scount, sphase, swcount;

  fetch_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] rd, input logic h, input logic tw,
                       input logic ld, input logic [AW-1:0] nw);
    bus.romData = rd;
    bus.hold    = h;
    bus.twoWord = tw;
    bus.pcLoad  = ld;
    bus.pcNew   = nw;
  endtask

  // Runs one full 8-phase cycle from phase 0 and records what was observed along the way.
  task automatic run_cycle(input logic [DW-1:0] m1, input logic [DW-1:0] m2, input logic tw,
                           input logic ld7, input logic ldo, input logic [AW-1:0] nw);
    vcount = 0; vphase = -1; scount = 0; sphase = -1; swcount = 0;
    for (int p = 0; p < 8; p++) begin
      drive((p == 3) ? m1 : ((p == 4) ? m2 : 4'h0), 1'b0, tw, (p == 7) ? ld7 : ldo, nw);
      #1;
      if (bus.instrValid) begin vcount++; vphase = int'(bus.cycle); end
      if (bus.sync) begin scount++; sphase = int'(bus.cycle); end
      if (bus.secondWord) swcount++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'hF, 1'b1, 1'b1, 1'b1, 12'hABC);
    tick();
    tick();
    checks++; if (bus.cycle !== 3'd0) begin errors++; $display("FAIL reset_cycle got %0d exp 0", bus.cycle); end
    checks++; if (bus.pcAddr !== 12'h000) begin errors++; $display("FAIL reset_pc got %h exp 000", bus.pcAddr); end
    checks++; if ({bus.opr, bus.opa, bus.opr2, bus.opa2} !== 16'h0000) begin
      errors++; $display("FAIL reset_operands got %h exp 0000", {bus.opr, bus.opa, bus.opr2, bus.opa2}); end
    checks++; if ({bus.secondWord, bus.instrValid, bus.sync} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {bus.secondWord, bus.instrValid, bus.sync}); end
    checks++; if (bus.instrAddr !== 12'h000) begin errors++; $display("FAIL reset_iaddr got %h exp 000", bus.instrAddr); end
    rst = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic test_basic();
    run_cycle(4'hA, 4'h3, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++; if (bus.opr !== 4'hA) begin errors++; $display("FAIL basic_opr got %h exp a", bus.opr); end
    checks++; if (bus.opa !== 4'h3) begin errors++; $display("FAIL basic_opa got %h exp 3", bus.opa); end
    checks++; if (vcount !== 1 || vphase !== 5) begin
      errors++; $display("FAIL basic_valid got count %0d phase %0d exp 1 at 5", vcount, vphase); end
    checks++; if (scount !== 1 || sphase !== 7) begin
      errors++; $display("FAIL basic_sync got count %0d phase %0d exp 1 at 7", scount, sphase); end
    checks++; if (bus.pcAddr !== 12'h001) begin errors++; $display("FAIL basic_pc got %h exp 001", bus.pcAddr); end
    checks++; if (bus.cycle !== 3'd0) begin errors++; $display("FAIL basic_wrap got %0d exp 0", bus.cycle); end
  endtask

  task automatic test_jump();
    run_cycle(4'h5, 4'h6, 1'b0, 1'b1, 1'b0, 12'h2F0);
    checks++; if (bus.pcAddr !== 12'h2F0 || bus.cycle !== 3'd0) begin
      errors++; $display("FAIL jump_pc got %h phase %0d exp 2f0 phase 0", bus.pcAddr, bus.cycle); end
    run_cycle(4'h1, 4'h2, 1'b0, 1'b0, 1'b1, 12'h555);
    checks++; if (bus.pcAddr !== 12'h2F1) begin errors++; $display("FAIL jump_off_phase got %h exp 2f1", bus.pcAddr); end
  endtask

  task automatic test_two_word();
    run_cycle(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 12'h010);
    run_cycle(4'h7, 4'h8, 1'b1, 1'b1, 1'b0, 12'h3AB);
    checks++; if (bus.pcAddr !== 12'h011) begin errors++; $display("FAIL tw_pc_first got %h exp 011", bus.pcAddr); end
    checks++; if (bus.secondWord !== 1'b1) begin errors++; $display("FAIL tw_second got %b exp 1", bus.secondWord); end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL tw_no_valid_first got %0d exp 0", vcount); end
    run_cycle(4'hC, 4'hD, 1'b1, 1'b0, 1'b0, 12'h000);
    checks++; if ({bus.opr, bus.opa, bus.opr2, bus.opa2} !== 16'h78CD) begin
      errors++; $display("FAIL tw_operands got %h exp 78cd", {bus.opr, bus.opa, bus.opr2, bus.opa2}); end
    checks++; if (vcount !== 1 || vphase !== 5) begin
      errors++; $display("FAIL tw_valid got count %0d phase %0d exp 1 at 5", vcount, vphase); end
    checks++; if (swcount !== 8) begin errors++; $display("FAIL tw_second_span got %0d exp 8", swcount); end
    checks++; if (bus.secondWord !== 1'b0 || bus.pcAddr !== 12'h012) begin
      errors++; $display("FAIL tw_return got sw %b pc %h exp 0 012", bus.secondWord, bus.pcAddr); end
    checks++; if (bus.instrAddr !== EXP_IA_2W) begin
      errors++; $display("FAIL tw_iaddr got %h exp %h", bus.instrAddr, EXP_IA_2W); end
  endtask

  task automatic test_wrap();
    run_cycle(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 12'hFFF);
    checks++; if (bus.pcAddr !== 12'hFFF) begin errors++; $display("FAIL wrap_load got %h exp fff", bus.pcAddr); end
    run_cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++; if (bus.pcAddr !== 12'h000) begin errors++; $display("FAIL wrap_pc got %h exp 000", bus.pcAddr); end
  endtask

  task automatic test_hold();
    run_cycle(4'h1, 4'h6, 1'b0, 1'b0, 1'b0, 12'h000);
    for (int p = 0; p < 4; p++) begin
      drive((p == 3) ? 4'h9 : 4'h0, 1'b0, 1'b0, 1'b0, 12'h000);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(4'hF, 1'b1, 1'b0, 1'b1, 12'h3C0);
      #1;
      checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b exp 0", bus.instrValid); end
      tick();
      checks++; if (bus.cycle !== 3'd4 || bus.opa !== 4'h6) begin
        errors++; $display("FAIL hold_freeze got phase %0d opa %h exp 4 6", bus.cycle, bus.opa); end
    end
    drive(4'h2, 1'b0, 1'b0, 1'b0, 12'h000);
    tick();
    checks++; if (bus.cycle !== 3'd5 || bus.opa !== 4'h2 || bus.pcAddr !== 12'h001) begin
      errors++; $display("FAIL hold_resume got phase %0d opa %h pc %h exp 5 2 001", bus.cycle, bus.opa, bus.pcAddr); end
    checks++; if (bus.instrValid !== 1'b1) begin errors++; $display("FAIL hold_resume_valid got %b exp 1", bus.instrValid); end
    tick();
    checks++; if (bus.instrValid !== 1'b0) begin errors++; $display("FAIL hold_valid_once got %b exp 0", bus.instrValid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'h0, 1'b1, 1'b0, 1'b1, 12'h123);
      tick();
    end
    checks++; if (bus.cycle !== 3'd7 || bus.pcAddr !== 12'h001 || bus.sync !== 1'b1) begin
      errors++; $display("FAIL hold_defer got phase %0d pc %h sync %b exp 7 001 1", bus.cycle, bus.pcAddr, bus.sync); end
    drive(4'h0, 1'b0, 1'b0, 1'b1, 12'h123);
    tick();
    checks++; if (bus.cycle !== 3'd0 || bus.pcAddr !== 12'h123) begin
      errors++; $display("FAIL hold_load got phase %0d pc %h exp 0 123", bus.cycle, bus.pcAddr); end
  endtask

  task automatic test_reset_mid();
    run_cycle(4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int p = 0; p < 3; p++) begin
      drive(4'h0, 1'b0, 1'b0, 1'b0, 12'h000);
      tick();
    end
    checks++; if (bus.cycle !== 3'd3 || bus.secondWord !== 1'b1 || bus.pcAddr !== 12'h124) begin
      errors++; $display("FAIL rmid_setup got phase %0d sw %b pc %h exp 3 1 124", bus.cycle, bus.secondWord, bus.pcAddr); end
    drive(4'hF, 1'b0, 1'b0, 1'b1, 12'h777);
    rst = 1'b1;
    tick();
    checks++; if (bus.cycle !== 3'd0 || bus.pcAddr !== 12'h000 || bus.secondWord !== 1'b0) begin
      errors++; $display("FAIL rmid_state got phase %0d pc %h sw %b exp 0 000 0", bus.cycle, bus.pcAddr, bus.secondWord); end
    checks++; if ({bus.opr, bus.opa, bus.opr2, bus.opa2} !== 16'h0000 || bus.instrValid !== 1'b0 || bus.instrAddr !== 12'h000) begin
      errors++; $display("FAIL rmid_outputs got %h v %b ia %h exp 0000 0 000",
                         {bus.opr, bus.opa, bus.opr2, bus.opa2}, bus.instrValid, bus.instrAddr); end
    rst = 1'b0;
    run_cycle(4'h4, 4'h5, 1'b0, 1'b0, 1'b0, 12'h000);
    checks++; if ({bus.opr, bus.opa, bus.opr2} !== 12'h450 || vcount !== 1 || bus.pcAddr !== 12'h001) begin
      errors++; $display("FAIL rmid_restart got ops %h valid %0d pc %h exp 450 1 001",
                         {bus.opr, bus.opa, bus.opr2}, vcount, bus.pcAddr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_two_word();
    test_wrap();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, program-counter width in bits (min 4).
REQ-002 SHALL have parameter DATA_W, default 4, ROM nibble width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port romData  input  DATA_W  ROM nibble at current address.
REQ-006 SHALL have port hold  input  1  freeze all state while high.
REQ-007 SHALL have port twoWord  input  1  decoder flag: current instruction has a second word.
REQ-008 SHALL have port pcLoad  input  1  jump/return request.
REQ-009 SHALL have port pcNew  input  ADDR_W  jump target.
REQ-010 SHALL have port cycle  output  3  phase 0..7 (A1,A2,A3,M1,M2,X1,X2,X3).
REQ-011 SHALL have port sync  output  1  high during phase 7.
REQ-012 SHALL have port pcAddr  output  ADDR_W  current fetch address.
REQ-013 SHALL have port opr, opa  output  DATA_W each  latched first-word nibbles.
REQ-014 SHALL have port opr2, opa2  output  DATA_W each  latched second-word nibbles.
REQ-015 SHALL have port secondWord  output  1  high throughout a second-word fetch cycle.
REQ-016 SHALL have port instrValid  output  1  one-cycle pulse: complete instruction latched.
REQ-017 SHALL have port instrAddr  output  ADDR_W  address of first word of current instruction.

Function
REQ-018 cycle SHALL increment by 1 per clock when hold=0, wrapping 7->0; unchanged when hold=1.
REQ-019 Phase 3 (M1), hold=0: SHALL latch romData into opr (first word) or opr2 (second word).
REQ-020 Phase 4 (M2), hold=0: SHALL latch romData into opa (first word) or opa2 (second word).
REQ-021 instrValid SHALL pulse in phase 5 of a first-word cycle with secondWord=0 and twoWord=0 sampled at phase 4, or in phase 5 of any second-word cycle; never pulses while hold=1.
REQ-022 twoWord SHALL be sampled at phase 7 of a first-word cycle; if 1, the next cycle SHALL be a second-word cycle (secondWord=1); a second-word cycle always returns to a first-word cycle.
REQ-023 At phase 7, hold=0: if pcLoad=1 and not a first-word cycle with twoWord=1, pcAddr SHALL take pcNew; else pcAddr SHALL increment modulo 2^ADDR_W (all-ones wraps to 0).
REQ-024 pcLoad during a first-word cycle with twoWord=1 SHALL be ignored (second word must be fetched first).
REQ-025 pcLoad and pcNew SHALL be sampled only at phase 7 with hold=0; pcLoad at other phases SHALL have no effect.
REQ-026 instrAddr SHALL capture pcAddr at phase 0 of each first-word cycle and hold through the second word.
REQ-027 hold=1 at phase 7 with pcLoad=1 SHALL defer the load until the clock where hold=0 at phase 7.
REQ-028 Latency: a pcNew loaded at phase 7 SHALL appear on pcAddr in the following phase 0.

Reset
REQ-029 rst=1 at clock edge SHALL set cycle=0, pcAddr=0, opr=opa=opr2=opa2=0, secondWord=0, instrValid=0, instrAddr=0, overriding hold and pcLoad.
REQ-030 Reset asserted mid-cycle or mid-second-word SHALL abandon the instruction; first clock after release is phase 0 fetching address 0.

Configuration
REQ-031 Macro FETCH_INSTR_ADDR_EN defined: instrAddr SHALL behave per REQ-026.
REQ-032 FETCH_INSTR_ADDR_EN undefined: instrAddr SHALL be constant 0 and no capture register SHALL exist.

Verification
REQ-033 Reset release, ROM returns 0xA at M1, 0x3 at M2 -> opr=0xA, opa=0x3, instrValid pulse at phase 5, pcAddr 0x000->0x001 after phase 7.
REQ-034 twoWord=1 at addr 0x010, pcLoad=1 at same phase 7 -> pcAddr=0x011, secondWord=1, opr2/opa2 latched, single instrValid in second cycle, instrAddr=0x010.
REQ-035 pcLoad=1, pcNew=0x2F0 at phase 7 of first-word cycle (twoWord=0) -> pcAddr=0x2F0 at next phase 0.
REQ-036 pcAddr=0xFFF, no load -> pcAddr=0x000 after phase 7.
REQ-037 hold=1 for 5 clocks at phase 4 -> cycle stays 4, opa unchanged, no instrValid; resume continues at phase 5.
REQ-038 rst=1 at phase 3 of second-word cycle -> all outputs zero next clock, secondWord=0.
